// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// holds the offered instruction across decode stalls. Optional: FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  input  logic [31:0] imem_dout,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        bubble,
  output logic        misalign_trap
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_instr_q;
  logic        hold_valid_q;
  logic        halted_s;
  logic        redir_bad_s;
  logic        redir_ok_s;
  logic [31:0] redir_tgt_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q;
  assign halted_s      = (state_q == HALT);
  assign redir_bad_s   = redirect && !halted_s && (redirect_pc[1:0] != 2'b00);
  assign redir_tgt_s   = redirect_pc;
  assign misalign_trap = trap_q;
`else
  assign halted_s      = 1'b0;
  assign redir_bad_s   = 1'b0;
  assign redir_tgt_s   = {redirect_pc[31:2], 2'b00};
  assign misalign_trap = 1'b0;
`endif

  // A misaligned redirect never reaches the memory; it only stops the stage.
  assign redir_ok_s = redirect && !halted_s && !redir_bad_s;
  assign pc         = pc_q;

  always_comb begin
    if (!rst_n) begin
      imem_addr = RESET_PC;
      imem_re   = 1'b1;
      bubble    = 1'b1;
      instr     = NOP;
    end else begin
      imem_re = !halted_s;
      if (redir_ok_s) begin
        imem_addr = redir_tgt_s;
      end else if (state_q == BOOT) begin
        imem_addr = pc_q;
      end else begin
        imem_addr = pc_q + 32'd4;
      end
      bubble = (state_q != RUN) || redirect;
      instr  = hold_valid_q ? hold_instr_q : imem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else if (redir_bad_s) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q      <= HALT;
      trap_q       <= 1'b1;
`endif
      hold_valid_q <= 1'b0;
    end else if (redir_ok_s) begin
      state_q      <= RUN;
      pc_q         <= redir_tgt_s;
      hold_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q      <= RUN;
          hold_valid_q <= 1'b0;
        end
        RUN: begin
          if (stall) begin
            hold_instr_q <= instr;
            hold_valid_q <= 1'b1;
          end else begin
            pc_q         <= pc_q + 32'd4;
            hold_valid_q <= 1'b0;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        HALT: begin
          state_q <= HALT;
        end
`endif
        default: begin
          state_q      <= BOOT;
          hold_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a PC-sequence model predicts every
// instruction decode accepts; a monitor pops and compares at each negedge.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_dout, instr, pc;
  logic        imem_re, bubble, misalign_trap;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_re(imem_re),
    .imem_dout(imem_dout), .instr(instr), .pc(pc), .bubble(bubble),
    .misalign_trap(misalign_trap)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  initial imem_dout = 32'h0;
  always @(posedge clk) if (imem_re) imem_dout <= mem_fn(imem_addr);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] ins; } acc_t;
  acc_t sbq[$];

  // Model: which PC decode will see next, and whether the stage is booting or halted.
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;
  logic [31:0] m_cur  = RPC;
  logic        exp_re, exp_trap;
  bit          mon_en = 1'b0;

  task automatic apply(input bit r, input bit s, input bit d, input logic [31:0] t);
    rst_n = r; stall = s; redirect = d; redirect_pc = t;
    exp_re   = r ? !m_halt : 1'b1;
    exp_trap = m_halt;
    if (!r) begin
      m_boot = 1'b1; m_halt = 1'b0; m_cur = RPC;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (d) begin
      if (TRAP && t[1:0] != 2'b00) begin
        m_halt = 1'b1;
      end else begin
        m_cur  = {t[31:2], 2'b00};
        m_boot = 1'b0;
      end
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!s) begin
      sbq.push_back('{pc: m_cur, ins: mem_fn(m_cur)});
      m_cur = m_cur + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      acc_t e;
      chk("imem_re", {31'd0, imem_re}, {31'd0, exp_re});
      chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, exp_trap});
      if (rst_n && !bubble) chk("instr_vs_mem", instr, mem_fn(pc));
      if (rst_n && !bubble && !stall) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_accept actual_pc=%h required=none", pc);
        end else begin
          e = sbq.pop_front();
          chk("accept_pc", pc, e.pc);
          chk("accept_instr", instr, e.ins);
        end
      end
    end
  end

  initial begin
    apply(1'b0, 1'b0, 1'b0, 32'h0); tick();
    mon_en = 1'b1;
    // Reset wins over stall and redirect.
    apply(1'b0, 1'b1, 1'b1, 32'h1234_5678); #1;
    chk("rst_addr", imem_addr, RPC);
    chk("rst_bubble", {31'd0, bubble}, 32'd1);
    chk("rst_instr", instr, NOP);
    chk("rst_re", {31'd0, imem_re}, 32'd1);
    tick();
    apply(1'b1, 1'b0, 1'b0, 32'h0); #1;
    chk("boot_bubble", {31'd0, bubble}, 32'd1);
    chk("boot_addr", imem_addr, RPC);
    tick();
    apply(1'b1, 1'b0, 1'b0, 32'h0); #1;
    chk("first_pc", pc, RPC);
    chk("first_bubble", {31'd0, bubble}, 32'd0);
    tick();
    apply(1'b1, 1'b0, 1'b0, 32'h0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0); #1;
      chk("stall_pc", pc, RPC + 32'd8);
      chk("stall_instr", instr, mem_fn(RPC + 32'd8));
      tick();
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0); tick();
    apply(1'b1, 1'b0, 1'b0, 32'h0); #1;
    chk("after_stall_pc", pc, RPC + 32'hC);
    tick();
    apply(1'b1, 1'b0, 1'b1, 32'h4000_0100); #1;
    chk("redir_pc_before", pc, RPC + 32'h10);
    chk("redir_bubble", {31'd0, bubble}, 32'd1);
    chk("redir_addr", imem_addr, 32'h4000_0100);
    tick();
    apply(1'b1, 1'b1, 1'b1, 32'h4000_0200); #1;
    chk("redir2_pc", pc, 32'h4000_0100);
    chk("redir2_addr", imem_addr, 32'h4000_0200);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0); #1;
      chk("redir_stall_pc", pc, 32'h4000_0200);
      chk("redir_stall_bubble", {31'd0, bubble}, 32'd0);
      tick();
    end
    apply(1'b1, 1'b0, 1'b1, 32'h4000_0102);
    if (!TRAP) begin
      #1 chk("mis_addr", imem_addr, 32'h4000_0100);
    end
    tick();
    apply(1'b1, 1'b0, 1'b0, 32'h0); #1;
    if (TRAP) begin
      chk("halt_bubble", {31'd0, bubble}, 32'd1);
    end else begin
      chk("mis_pc", pc, 32'h4000_0100);
    end
    tick();
    apply(1'b1, 1'b1, 1'b0, 32'h0); tick();
    apply(1'b1, 1'b1, 1'b0, 32'h0); tick();
    apply(1'b0, 1'b1, 1'b0, 32'h0); tick();
    apply(1'b1, 1'b0, 1'b0, 32'h0); #1;
    chk("rerst_pc", pc, RPC);
    chk("rerst_bubble", {31'd0, bubble}, 32'd1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      bit r, s, d;
      logic [31:0] t;
      r = ($urandom_range(99) >= 2);
      s = ($urandom_range(99) < 30);
      d = ($urandom_range(99) < 10);
      t = RPC + ($urandom_range(1023) << 2);
      if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3));
      if ($urandom_range(49) == 0) t = 32'hFFFF_FFFC;
      apply(r, s, d, t);
      tick();
    end
    apply(1'b1, 1'b1, 1'b0, 32'h0); tick();
    mon_en = 1'b0;
    chk("sb_leftover", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
